// File: rtl/spi_shift_engine.sv
// Full-duplex SPI master shift engine (CPHA=0, selectable CPOL).
// One word per valid/ready handshake; received word returned with a one-cycle rx_dv pulse.
module spi_shift_engine #(
  parameter int   W_DATA  = 32,
  parameter int   CLK_DIV = 4,
  parameter logic CPOL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_DATA-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [W_DATA-1:0] rx_data,
  output logic              rx_dv,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(W_DATA + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W_DATA);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     div_reg;
  logic [BW-1:0]     bit_reg;
  logic [W_DATA-1:0] tx_shift_reg;
  logic [W_DATA-1:0] rx_shift_reg;
  logic [W_DATA-1:0] rx_data_reg;
  logic              sclk_reg;

  logic accept;
  logic div_tc;
  logic leading;

  assign accept  = tx_valid && tx_ready;
  assign div_tc  = (div_reg == DIV_LAST);
  // The next toggle leaves the idle level exactly when spi_clk currently sits at CPOL.
  assign leading = (sclk_reg == CPOL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tx_ready   = 1'b0;
    rx_dv      = 1'b0;
    spi_cs_n   = 1'b1;
    spi_mosi   = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_ready = 1'b1;
        if (accept) state_next = LEAD;
      end
      LEAD: begin
        spi_cs_n = 1'b0;
        spi_mosi = tx_shift_reg[W_DATA-1];
        if (div_tc) state_next = SHIFT;
      end
      SHIFT: begin
        spi_cs_n = 1'b0;
        spi_mosi = tx_shift_reg[W_DATA-1];
        if (div_tc && !leading && (bit_reg == BIT_LAST)) state_next = TRAIL;
      end
      TRAIL: begin
        spi_cs_n = 1'b0;
        spi_mosi = tx_shift_reg[W_DATA-1];
        if (div_tc) state_next = DONE;
      end
      DONE: begin
        tx_ready   = 1'b1;
        rx_dv      = 1'b1;
        state_next = accept ? LEAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg      <= '0;
      bit_reg      <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      sclk_reg     <= CPOL;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            tx_shift_reg <= tx_data;
            rx_shift_reg <= '0;
            bit_reg      <= '0;
            div_reg      <= '0;
            sclk_reg     <= CPOL;
          end
        end
        LEAD: begin
          div_reg <= div_tc ? '0 : div_reg + DW'(1);
        end
        SHIFT: begin
          div_reg <= div_tc ? '0 : div_reg + DW'(1);
          if (div_tc) begin
            sclk_reg <= ~sclk_reg;
            if (leading) begin
              rx_shift_reg <= (rx_shift_reg << 1) | W_DATA'(spi_miso);
              bit_reg      <= bit_reg + BW'(1);
            end else if (bit_reg != BIT_LAST) begin
              // Final trailing edge leaves bit 0 on spi_mosi.
              tx_shift_reg <= tx_shift_reg << 1;
            end
          end
        end
        TRAIL: begin
          div_reg <= div_tc ? '0 : div_reg + DW'(1);
          if (div_tc) rx_data_reg <= rx_shift_reg;
        end
        default: ;
      endcase
    end
  end

  assign rx_data = rx_data_reg;
  assign spi_clk = sclk_reg;
  assign busy    = ~tx_ready;

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Full-duplex SPI master serializer/deserializer. Sits directly downstream of the SPI register file.
- Accepts one W_DATA-bit word per transfer from the register file over a valid/ready handshake.
- Shifts the word out MSB-first on spi_mosi while capturing spi_miso, then returns the received word with a one-cycle rx_dv pulse.
- Generates spi_clk and spi_cs_n. SPI mode is fixed to CPHA=0; CPOL is selectable.

Parameters:
- W_DATA, 32 (`W_CPU): transfer word width in bits; must be >= 1.
- CLK_DIV, 4: clk cycles per spi_clk half-period; also the length of the LEAD and TRAIL phases; must be >= 1.
- CPOL, 0: idle level of spi_clk.

Ports:
- clk  in  1  system clock; all logic is on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- tx_data  in  W_DATA  word to transmit; captured on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  engine can accept a word.
- rx_data  out  W_DATA  last fully received word.
- rx_dv  out  1  one-cycle pulse; rx_data updated.
- busy  out  1  transfer in progress; always equal to ~tx_ready.
- spi_clk  out  1  serial clock.
- spi_cs_n  out  1  chip select, active-low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in. Sampled directly with no synchronizer; the source is synchronous to clk.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, tx_ready=1, busy=0, rx_data=0, rx_dv=0, spi_clk=CPOL, spi_cs_n=1, spi_mosi=0. All counters and shift registers are cleared.
- Reset mid-transfer: same result at the next edge. The partial rx word is discarded and no rx_dv is produced.
- Handshake: a word is accepted on a posedge with tx_valid&&tx_ready. tx_data is copied into the tx shift register. tx_ready=0 from the following cycle.
- While busy, tx_valid and tx_data are ignored.
- States: IDLE, LEAD, SHIFT, TRAIL, DONE. Transitions:
  - IDLE -> LEAD on accept.
  - LEAD -> SHIFT after CLK_DIV cycles.
  - SHIFT -> TRAIL after the W_DATA-th trailing edge.
  - TRAIL -> DONE after CLK_DIV cycles.
  - DONE -> IDLE, or DONE -> LEAD if a word is accepted in DONE.
- LEAD (CLK_DIV cycles): spi_cs_n=0, spi_clk=CPOL, spi_mosi = tx bit W_DATA-1.
- SHIFT:
  - A divider counts 0..CLK_DIV-1. On terminal count, spi_clk toggles.
  - Leading edge (spi_clk leaves CPOL): spi_miso is shifted into the rx shift register LSB, and the bit counter increments.
  - Trailing edge (spi_clk returns to CPOL): the tx register shifts left and spi_mosi takes the next bit.
  - The W_DATA-th trailing edge does not shift; spi_mosi holds bit 0.
  - Exactly W_DATA leading edges occur per transfer.
- TRAIL (CLK_DIV cycles): spi_cs_n=0, spi_clk=CPOL.
- DONE (exactly 1 cycle): spi_cs_n=1, rx_data = rx shift register, rx_dv=1, tx_ready=1.
- Guaranteed spi_cs_n high gap between back-to-back words: at least one cycle.
- Latency: accept at edge T gives rx_dv high in cycle T + 2*CLK_DIV + 2*W_DATA*CLK_DIV + 1. For defaults this is T+265.
- rx_data holds its value until the next DONE or rst.
- CLK_DIV=1: spi_clk toggles every cycle, with no other change in protocol.

Test Plan:
- Reset: assert rst 2 cycles mid-idle -> tx_ready=1, busy=0, rx_dv=0, rx_data=0, spi_cs_n=1, spi_clk=0, spi_mosi=0.
- Loopback, defaults (spi_miso tied to spi_mosi), tx_data=0xA5A50F0F, accept at T:
  - spi_cs_n falls at T+1.
  - Exactly 32 rising spi_clk edges occur.
  - MSB-first bits observed on spi_mosi at each rising edge.
  - rx_dv=1 only in cycle T+265, with rx_data=0xA5A50F0F.
- spi_miso held 1, tx_data=0x00000000 -> rx_data=0xFFFFFFFF and spi_mosi=0 throughout. Then spi_miso held 0 -> rx_data=0x00000000.
- Back-to-back: tx_valid held high with words 0x12345678 then 0xDEADBEEF (loopback):
  - Second accept occurs in the DONE cycle.
  - spi_cs_n high exactly 1 cycle between words.
  - rx_dv pulses twice, with rx_data 0x12345678 then 0xDEADBEEF.
- Busy ignore: pulse tx_valid with 0xFFFFFFFF during SHIFT of 0x0000000F -> no effect; received loopback word=0x0000000F.
- Reset mid-SHIFT after 10 leading edges -> next cycle shows reset values and no rx_dv. A subsequent word 0x0F0F0F0F then completes normally.
- CPOL=1, CLK_DIV=1, W_DATA=8, loopback, tx_data=0x81 -> spi_clk idles high, 8 falling edges, rx_data=0x81 at T+19.
